audio_pwm_out: RTL and testbench

AUDIO_PWM_OUT -- requirements
Module: audio_pwm_out

---
 rtl/audio_pkg.sv | 28 ++
 rtl/sync_fifo.sv | 58 +++++
 rtl/audio_pwm_out.sv | 123 ++++++++++++
 tb/tb_audio_pwm_out.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared definitions for the PWM audio output block: register offsets,
// STATUS/CTRL bit positions and the sample type.
package audio_pkg;

  typedef logic signed [15:0] sample_t;

  typedef enum logic [1:0] {
    REG_CTRL   = 2'd0,
    REG_STATUS = 2'd1,
    REG_DATA   = 2'd2,
    REG_DIV    = 2'd3
  } reg_addr_t;

  localparam int CTRL_ENABLE = 0;
  localparam int CTRL_FLUSH  = 1;

  localparam int STAT_FULL      = 0;
  localparam int STAT_EMPTY     = 1;
  localparam int STAT_UNDERRUN  = 2;
  localparam int STAT_OVERFLOW  = 3;
  localparam int STAT_LEVEL_LSB = 8;

  // Signed two's complement to offset binary: midscale 0 maps to 0x8000.
  function automatic logic [15:0] offset_binary(input sample_t s);
    return s ^ 16'h8000;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with push/pop/flush; flush wins over everything else,
// and a push on a full FIFO is accepted only when a pop frees a slot that cycle.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == '0);
  assign full    = (level == FULL_LEVEL);
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/audio_pwm_out.sv
// Memory-mapped PWM audio output: samples are queued in a FIFO, consumed at the
// sample rate set by DIV, and rendered as an offset-binary PWM duty cycle.
module audio_pwm_out
  import audio_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int PWM_BITS   = 10,
  parameter int DIV_RESET  = 1134
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        pwm_out
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  reg_addr_t           reg_sel;
  logic                wr_ctrl, wr_status, wr_data, wr_div;
  logic                enable, underrun, overflow;
  logic [15:0]         div_reg, period_cnt;
  logic                tick, flush, pop_ok;
  sample_t             cur_sample, fifo_head;
  logic                fifo_full, fifo_empty;
  logic [LW-1:0]       fifo_level;
  logic [PWM_BITS-1:0] pwm_cnt, duty;
  logic [15:0]         sample_ob;
  logic [31:0]         rd_next;
  logic                unused_ok;

  assign reg_sel   = reg_addr_t'(addr[3:2]);
  assign wr_ctrl   = we && (reg_sel == REG_CTRL);
  assign wr_status = we && (reg_sel == REG_STATUS);
  assign wr_data   = we && (reg_sel == REG_DATA);
  assign wr_div    = we && (reg_sel == REG_DIV);
  assign flush     = wr_ctrl && wd[CTRL_FLUSH];
  assign tick      = enable && (period_cnt == div_reg - 16'd1);
  // A flush in the same cycle as a tick suppresses the pop so the sample holds.
  assign pop_ok    = tick && !fifo_empty && !flush;
  assign sample_ob = offset_binary(cur_sample);
  assign unused_ok = ^{addr[31:4], addr[1:0], wd[31:16], sample_ob};

  sync_fifo #(
    .WIDTH(16),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_data),
    .pop   (tick),
    .flush (flush),
    .wdata (wd[15:0]),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable   <= 1'b0;
      underrun <= 1'b0;
      overflow <= 1'b0;
      div_reg  <= 16'(DIV_RESET);
    end else begin
      if (wr_ctrl) enable <= wd[CTRL_ENABLE];
      if (wr_div)  div_reg <= (wd[15:0] < 16'd2) ? 16'd2 : wd[15:0];
      underrun <= (underrun && !(wr_status && wd[STAT_UNDERRUN])) || (tick && fifo_empty);
      overflow <= (overflow && !(wr_status && wd[STAT_OVERFLOW])) ||
                  (wr_data && fifo_full && !pop_ok);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period_cnt <= '0;
      cur_sample <= '0;
    end else begin
      if (wr_div || !enable || tick) period_cnt <= '0;
      else                           period_cnt <= period_cnt + 16'd1;
      if (pop_ok) cur_sample <= fifo_head;
    end
  end

  // Duty is only reloaded when the PWM counter restarts, so no period is cut short.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_cnt <= '0;
      duty    <= {1'b1, {(PWM_BITS-1){1'b0}}};
      pwm_out <= 1'b0;
    end else begin
      pwm_out <= enable && (pwm_cnt < duty);
      pwm_cnt <= enable ? pwm_cnt + PWM_BITS'(1) : '0;
      if (!enable || (pwm_cnt == '1)) duty <= sample_ob[15 -: PWM_BITS];
    end
  end

  always_comb begin
    rd_next = '0;
    case (reg_sel)
      REG_CTRL:   rd_next[CTRL_ENABLE] = enable;
      REG_STATUS: begin
        rd_next[STAT_FULL]                = fifo_full;
        rd_next[STAT_EMPTY]               = fifo_empty;
        rd_next[STAT_UNDERRUN]            = underrun;
        rd_next[STAT_OVERFLOW]            = overflow;
        rd_next[STAT_LEVEL_LSB +: LW]     = fifo_level;
      end
      REG_DATA:   rd_next = '0;
      REG_DIV:    rd_next[15:0] = div_reg;
      default:    rd_next = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rd <= '0;
    else       rd <= rd_next;
  end

endmodule

// File: tb/tb_audio_pwm_out.sv
// Self-checking bench for audio_pwm_out: directed scenarios plus a randomized
// register-traffic run compared against a queue-based behavioural model.
module tb_audio_pwm_out;

  localparam int FIFO_DEPTH = 16;
  localparam int PWM_BITS   = 10;
  localparam int DIV_RESET  = 1134;

  localparam logic [31:0] A_CTRL   = 32'h0;
  localparam logic [31:0] A_STATUS = 32'h4;
  localparam logic [31:0] A_DATA   = 32'h8;
  localparam logic [31:0] A_DIV    = 32'hC;

  logic        clk, reset, we, pwm_out;
  logic [31:0] addr, wd, rd;

  int n_checks;
  int n_fail;

  logic [15:0] m_q[$];
  bit          m_en, m_under, m_over, m_pwm;
  int          m_div, m_pcnt, m_wcnt, m_duty;
  logic [15:0] m_sample;
  logic [31:0] m_rd;

  audio_pwm_out #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .PWM_BITS  (PWM_BITS),
    .DIV_RESET (DIV_RESET)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .we     (we),
    .addr   (addr),
    .wd     (wd),
    .rd     (rd),
    .pwm_out(pwm_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  function automatic int duty_of(input logic [15:0] s);
    logic [15:0] ob;
    ob = s ^ 16'h8000;
    return int'(ob >> (16 - PWM_BITS));
  endfunction

  function automatic void model_reset();
    m_q.delete();
    m_en = 0; m_under = 0; m_over = 0; m_pwm = 0;
    m_div = DIV_RESET; m_pcnt = 0; m_wcnt = 0;
    m_sample = 16'h0000;
    m_duty = duty_of(16'h0000);
    m_rd = 32'h0;
  endfunction

  // Behavioural model of one clock edge, using the state as it was before the edge.
  task automatic model_step(input logic w, input logic [31:0] a, input logic [31:0] d);
    int sel, level, new_pcnt, new_wcnt;
    bit tk, popped, set_under, set_over, new_pwm;
    logic [15:0] new_sample;
    sel = int'(a[3:2]);
    level = m_q.size();
    case (sel)
      0: m_rd = {31'd0, m_en};
      1: m_rd = 32'(level * 256 + (m_over ? 8 : 0) + (m_under ? 4 : 0) +
                    (level == 0 ? 2 : 0) + (level == FIFO_DEPTH ? 1 : 0));
      2: m_rd = 32'h0;
      default: m_rd = 32'(m_div);
    endcase
    tk = m_en && (m_pcnt == m_div - 1);
    popped = 0;
    set_over = 0;
    set_under = tk && (level == 0);
    new_sample = m_sample;
    if (w && sel == 0 && d[1]) begin
      m_q.delete();
    end else begin
      if (tk && level > 0) begin
        new_sample = m_q.pop_front();
        popped = 1;
      end
      if (w && sel == 2) begin
        if (level < FIFO_DEPTH || popped) m_q.push_back(d[15:0]);
        else set_over = 1;
      end
    end
    new_pwm  = m_en && (m_wcnt < m_duty);
    new_wcnt = m_en ? (m_wcnt + 1) % (1 << PWM_BITS) : 0;
    if (new_wcnt == 0) m_duty = duty_of(m_sample);
    new_pcnt = (m_en && !tk) ? m_pcnt + 1 : 0;
    if (w && sel == 0) m_en = d[0];
    if (w && sel == 1) begin
      if (d[2]) m_under = 0;
      if (d[3]) m_over = 0;
    end
    if (set_under) m_under = 1;
    if (set_over) m_over = 1;
    if (w && sel == 3) begin
      m_div = (d[15:0] < 16'd2) ? 2 : int'(d[15:0]);
      new_pcnt = 0;
    end
    m_pcnt = new_pcnt;
    m_wcnt = new_wcnt;
    m_pwm = new_pwm;
    m_sample = new_sample;
  endtask

  // One bus cycle: called at a negedge, returns at the following negedge.
  task automatic cycle(input logic w, input logic [31:0] a, input logic [31:0] d);
    we = w; addr = a; wd = d;
    @(posedge clk);
    model_step(w, a, d);
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; we = 1'b0; addr = '0; wd = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if (rd !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_rd_async: got %h expected %h", rd, 32'h0); end
    n_checks++;
    if (pwm_out !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_pwm_async: got %b expected 0", pwm_out); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    cycle(0, A_STATUS, 0);
    n_checks++;
    if (rd !== 32'h2) begin n_fail++; $display("[TB] FAIL reset_status: got %h expected %h", rd, 32'h2); end
    cycle(0, A_DIV, 0);
    n_checks++;
    if (rd !== 32'(DIV_RESET)) begin n_fail++; $display("[TB] FAIL reset_div: got %h expected %h", rd, 32'(DIV_RESET)); end
    cycle(0, A_CTRL, 0);
    n_checks++;
    if (rd !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_ctrl: got %h expected %h", rd, 32'h0); end
    n_checks++;
    if (pwm_out !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_pwm: got %b expected 0", pwm_out); end
  endtask

  task automatic test_playback();
    logic [31:0] exp;
    int highs, exp_highs;
    do_reset();
    cycle(1, A_DIV, 32'd4);
    cycle(1, A_DATA, 32'h0000_7FFF);
    cycle(1, A_CTRL, 32'h1);
    for (int i = 1; i <= 5; i++) begin
      cycle(0, A_STATUS, 0);
      exp = (i < 5) ? 32'h100 : 32'h2;
      n_checks++;
      if (rd !== exp) begin n_fail++; $display("[TB] FAIL playback_pop_time[%0d]: got %h expected %h", i, rd, exp); end
    end
    repeat (1100) cycle(0, A_CTRL, 0);
    highs = 0;
    for (int i = 0; i < 1024; i++) begin
      cycle(0, A_CTRL, 0);
      highs += int'(pwm_out);
      n_checks++;
      if (pwm_out !== m_pwm) begin n_fail++; $display("[TB] FAIL playback_pwm[%0d]: got %b expected %b", i, pwm_out, m_pwm); end
    end
    exp_highs = duty_of(16'h7FFF);
    n_checks++;
    if (highs != exp_highs) begin n_fail++; $display("[TB] FAIL playback_duty: got %0d expected %0d", highs, exp_highs); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < FIFO_DEPTH + 1; i++) cycle(1, A_DATA, $urandom());
    cycle(0, A_STATUS, 0);
    n_checks++;
    if (rd !== 32'h0000_1009) begin n_fail++; $display("[TB] FAIL overflow_status: got %h expected %h", rd, 32'h0000_1009); end
    cycle(1, A_STATUS, 32'h8);
    cycle(0, A_STATUS, 0);
    n_checks++;
    if (rd !== 32'h0000_1001) begin n_fail++; $display("[TB] FAIL overflow_clear: got %h expected %h", rd, 32'h0000_1001); end
  endtask

  task automatic test_underrun();
    logic [31:0] exp;
    int highs, exp_highs;
    do_reset();
    cycle(1, A_DIV, 32'd2);
    cycle(1, A_CTRL, 32'h1);
    for (int i = 1; i <= 3; i++) begin
      cycle(0, A_STATUS, 0);
      exp = (i < 3) ? 32'h2 : 32'h6;
      n_checks++;
      if (rd !== exp) begin n_fail++; $display("[TB] FAIL underrun_status[%0d]: got %h expected %h", i, rd, exp); end
    end
    repeat (1100) cycle(0, A_CTRL, 0);
    highs = 0;
    for (int i = 0; i < 1024; i++) begin
      cycle(0, A_CTRL, 0);
      highs += int'(pwm_out);
    end
    exp_highs = duty_of(16'h0000);
    n_checks++;
    if (highs != exp_highs) begin n_fail++; $display("[TB] FAIL underrun_duty: got %0d expected %0d", highs, exp_highs); end
  endtask

  task automatic test_back_to_back();
    bit found;
    do_reset();
    cycle(1, A_DIV, 32'd8);
    for (int i = 0; i < FIFO_DEPTH; i++) cycle(1, A_DATA, $urandom());
    cycle(1, A_CTRL, 32'h1);
    cycle(0, A_STATUS, 0);
    n_checks++;
    if (rd !== 32'h0000_1001) begin n_fail++; $display("[TB] FAIL b2b_full: got %h expected %h", rd, 32'h0000_1001); end
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (m_en && (m_pcnt == m_div - 1)) found = 1;
      else cycle(0, A_CTRL, 0);
    end
    n_checks++;
    if (!found) begin n_fail++; $display("[TB] FAIL b2b_tick_wait: got no tick expected tick within 20 cycles"); end
    cycle(1, A_DATA, $urandom());
    cycle(0, A_STATUS, 0);
    n_checks++;
    if (rd !== 32'h0000_1001) begin n_fail++; $display("[TB] FAIL b2b_push_tick: got %h expected %h", rd, 32'h0000_1001); end
    cycle(1, A_CTRL, 32'h3);
    cycle(0, A_STATUS, 0);
    n_checks++;
    if (rd !== 32'h0000_0002) begin n_fail++; $display("[TB] FAIL b2b_flush: got %h expected %h", rd, 32'h0000_0002); end
    cycle(0, A_CTRL, 0);
    n_checks++;
    if (rd !== 32'h1) begin n_fail++; $display("[TB] FAIL b2b_ctrl: got %h expected %h", rd, 32'h1); end
  endtask

  task automatic test_random();
    logic [31:0] a, d, noise;
    logic        w;
    int          r;
    do_reset();
    cycle(1, A_DIV | ($urandom() & 32'hFFFF_FFF0), 32'd5);
    cycle(1, A_CTRL, 32'h1);
    for (int i = 0; i < 3000; i++) begin
      noise = $urandom() & 32'hFFFF_FFF3;
      r = int'($urandom_range(0, 99));
      w = 1'b1;
      d = $urandom();
      if (r < 50) begin
        w = 1'b0;
        a = noise | (32'($urandom_range(0, 3)) << 2);
      end else if (r < 75) begin
        a = noise | A_DATA;
      end else if (r < 83) begin
        a = noise | A_CTRL;
        d[0] = ($urandom_range(0, 3) != 0);
        d[1] = ($urandom_range(0, 7) == 0);
      end else if (r < 90) begin
        a = noise | A_STATUS;
      end else begin
        a = noise | A_DIV;
        d = (d & 32'hFFFF_0000) | 32'($urandom_range(0, 12));
      end
      cycle(w, a, d);
      n_checks++;
      if (rd !== m_rd) begin n_fail++; $display("[TB] FAIL random_rd[%0d]: got %h expected %h", i, rd, m_rd); end
      n_checks++;
      if (pwm_out !== m_pwm) begin n_fail++; $display("[TB] FAIL random_pwm[%0d]: got %b expected %b", i, pwm_out, m_pwm); end
    end
  endtask

  task automatic test_reset_midplay();
    do_reset();
    cycle(1, A_DIV, 32'd3);
    for (int i = 0; i < 4; i++) cycle(1, A_DATA, 32'h0000_7FFF);
    cycle(1, A_CTRL, 32'h1);
    repeat (40) cycle(0, A_CTRL, 0);
    cycle(0, A_DIV, 0);
    n_checks++;
    if (rd !== 32'd3) begin n_fail++; $display("[TB] FAIL midplay_div: got %h expected %h", rd, 32'd3); end
    #2 reset = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if (pwm_out !== 1'b0) begin n_fail++; $display("[TB] FAIL midplay_pwm: got %b expected 0", pwm_out); end
    n_checks++;
    if (rd !== 32'h0) begin n_fail++; $display("[TB] FAIL midplay_rd: got %h expected %h", rd, 32'h0); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    cycle(0, A_STATUS, 0);
    n_checks++;
    if (rd !== 32'h2) begin n_fail++; $display("[TB] FAIL midplay_status: got %h expected %h", rd, 32'h2); end
    cycle(0, A_CTRL, 0);
    n_checks++;
    if (rd !== 32'h0) begin n_fail++; $display("[TB] FAIL midplay_ctrl: got %h expected %h", rd, 32'h0); end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    reset = 1'b0; we = 1'b0; addr = '0; wd = '0;
    model_reset();
    test_reset();
    test_playback();
    test_overflow();
    test_underrun();
    test_back_to_back();
    test_random();
    test_reset_midplay();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
